ttt_game_fsm: RTL and testbench

//  Game engine directly downstream of the keypad scanner.
//  - Consumes the scanner's 12-bit one-hot key_data.
//  - Qualifies key presses and runs the tic-tac-toe flow: main screen, play, result.
//  - Holds the 3x3 board and the turn, and detects win or draw.
//  - Drives the 7-segment main screen select (in_main) and the dot-matrix renderer (board_x/board_o).

---
 rtl/ttt_game_fsm_if.sv | 47 ++++
 rtl/ttt_game_fsm.sv | 277 +++++++++++++++++++++++++++
 tb/tb_ttt_game_fsm.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ttt_game_fsm_if.sv
// ttt_game_fsm_if
// Connects the keypad scanner to the tic-tac-toe game engine, and the game engine
// to the display renderers.
// Signals:
//   key_data  [11:0] one-hot key from the scanner (bit0..8 = cells 0..8, bit9 '*', bit10 '0', bit11 '#')
//   in_main          main/start screen active
//   board_x   [8:0]  cells holding X
//   board_o   [8:0]  cells holding O
//   turn_o           0 = X to move, 1 = O to move
//   game_over        game finished (win or draw)
//   winner    [1:0]  00 none, 01 X, 10 O, 11 draw
//   move_cnt  [3:0]  marks placed
//   key_evt          one-cycle pulse per qualified press
//   illegal          one-cycle pulse on a press onto an occupied cell
//   win_line  [8:0]  cells of every completed winning line (only with TTT_WINLINE_EN)
// Modports: master = key source / display side, slave = game engine.
interface ttt_game_fsm_if;
  logic [11:0] key_data;
  logic        in_main;
  logic [8:0]  board_x;
  logic [8:0]  board_o;
  logic        turn_o;
  logic        game_over;
  logic [1:0]  winner;
  logic [3:0]  move_cnt;
  logic        key_evt;
  logic        illegal;
`ifdef TTT_WINLINE_EN
  logic [8:0]  win_line;
`endif

  modport master (
`ifdef TTT_WINLINE_EN
    input  win_line,
`endif
    output key_data,
    input  in_main, board_x, board_o, turn_o, game_over, winner, move_cnt, key_evt, illegal
  );

  modport slave (
`ifdef TTT_WINLINE_EN
    output win_line,
`endif
    input  key_data,
    output in_main, board_x, board_o, turn_o, game_over, winner, move_cnt, key_evt, illegal
  );
endinterface

// File: rtl/ttt_game_fsm.sv
// ttt_game_fsm
// Tic-tac-toe game engine fed directly by the keypad scanner. It qualifies key
// presses (debounce plus one event per press), runs the main/play/result flow,
// holds the 3x3 board and the turn, and detects a win or a draw.
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   ttt_game_fsm_if.slave: key_data in; board, turn, result and pulse outputs
// Parameter:
//   STABLE_CYC  cycles key_data must hold a value to count as a press or a release
// Build option:
//   TTT_WINLINE_EN  adds bus.win_line, the cells of the completed winning line(s)
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_MAIN  | start screen; only key 1 starts a game
// ST_PLAY  | waiting for the mover to press a cell, '*' aborts
// ST_CHECK | one cycle: evaluate the last move for win / draw / next turn
// ST_OVER  | board frozen, result shown; '#' replays, '*' goes to main
module ttt_game_fsm #(
  parameter logic [15:0] STABLE_CYC = 16'd1000
) (
  input  logic          clk,
  input  logic          rst,
  ttt_game_fsm_if.slave bus
);

  localparam logic [1:0] ST_MAIN  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam logic [3:0] KEY_START = 4'd0;
  localparam logic [3:0] KEY_STAR  = 4'd9;
  localparam logic [3:0] KEY_HASH  = 4'd11;

  // Down-counter reload: the counter reaches 0 once the registered key has been
  // unchanged for STABLE_CYC cycles.
  localparam logic [15:0] CNT_LOAD = (STABLE_CYC == 16'd0) ? 16'd0 : STABLE_CYC - 16'd1;

  function automatic logic [8:0] line_mask(input int unsigned n);
    case (n)
      0:       line_mask = 9'h007;
      1:       line_mask = 9'h038;
      2:       line_mask = 9'h1C0;
      3:       line_mask = 9'h049;
      4:       line_mask = 9'h092;
      5:       line_mask = 9'h124;
      6:       line_mask = 9'h111;
      default: line_mask = 9'h054;
    endcase
  endfunction

  // ---------------------------------------------------------------- qualifier
  logic [11:0] key_q, key_d;
  logic [15:0] cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic        key_evt_q, key_evt_d;
  logic [3:0]  key_idx_q, key_idx_d;

  logic        key_onehot;
  logic        key_stable;
  logic [3:0]  key_enc;

  always_comb begin
    key_onehot = (key_q != 12'd0) && ((key_q & (key_q - 12'd1)) == 12'd0);
    key_stable = (cnt_q == 16'd0);
    key_enc    = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (key_q[i]) key_enc = 4'(i);
    end
  end

  always_comb begin
    key_d     = bus.key_data;
    key_evt_d = 1'b0;
    armed_d   = armed_q;
    key_idx_d = key_idx_q;

    if (bus.key_data != key_q) cnt_d = CNT_LOAD;
    else if (cnt_q != 16'd0)   cnt_d = cnt_q - 16'd1;
    else                       cnt_d = cnt_q;

    if (armed_q && key_stable && key_onehot) begin
      key_evt_d = 1'b1;
      key_idx_d = key_enc;
      armed_d   = 1'b0;
    end else if (!armed_q && key_stable && (key_q == 12'd0)) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q     <= '0;
      cnt_q     <= '0;
      armed_q   <= 1'b1;
      key_evt_q <= 1'b0;
      key_idx_q <= '0;
    end else begin
      key_q     <= key_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      key_evt_q <= key_evt_d;
      key_idx_q <= key_idx_d;
    end
  end

  // --------------------------------------------------------------- game FSM
  logic [1:0] state_q, state_d;
  logic       in_main_q, in_main_d;
  logic [8:0] board_x_q, board_x_d;
  logic [8:0] board_o_q, board_o_d;
  logic       turn_q, turn_d;
  logic       game_over_q, game_over_d;
  logic [1:0] winner_q, winner_d;
  logic [3:0] move_cnt_q, move_cnt_d;
  logic       illegal_q, illegal_d;
`ifdef TTT_WINLINE_EN
  logic [8:0] win_line_q, win_line_d;
`endif

  logic [8:0] mover_board;
  logic [8:0] line_hits;
  logic [8:0] cell_m;
  logic       cell_key;
  logic       cell_busy;

  always_comb begin
    mover_board = turn_q ? board_o_q : board_x_q;
    line_hits   = 9'd0;
    for (int unsigned n = 0; n < 8; n++) begin
      if ((mover_board & line_mask(n)) == line_mask(n)) line_hits = line_hits | line_mask(n);
    end
    cell_key  = (key_idx_q < 4'd9);
    cell_m    = 9'h001 << key_idx_q;
    cell_busy = |((board_x_q | board_o_q) & cell_m);
  end

  always_comb begin
    state_d     = state_q;
    in_main_d   = in_main_q;
    board_x_d   = board_x_q;
    board_o_d   = board_o_q;
    turn_d      = turn_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    move_cnt_d  = move_cnt_q;
    illegal_d   = 1'b0;
`ifdef TTT_WINLINE_EN
    win_line_d  = win_line_q;
`endif

    case (state_q)
      ST_MAIN: begin
        if (key_evt_q && key_idx_q == KEY_START) begin
          board_x_d  = '0;
          board_o_d  = '0;
          move_cnt_d = '0;
          turn_d     = 1'b0;
          winner_d   = 2'b00;
          in_main_d  = 1'b0;
          state_d    = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (key_evt_q) begin
          if (cell_key) begin
            if (cell_busy) begin
              illegal_d = 1'b1;
            end else begin
              if (turn_q) board_o_d = board_o_q | cell_m;
              else        board_x_d = board_x_q | cell_m;
              move_cnt_d = move_cnt_q + 4'd1;
              state_d    = ST_CHECK;
            end
          end else if (key_idx_q == KEY_STAR) begin
            // Abort also zeroes the move count so it keeps matching the empty board.
            board_x_d  = '0;
            board_o_d  = '0;
            move_cnt_d = '0;
            turn_d     = 1'b0;
            in_main_d  = 1'b1;
            state_d    = ST_MAIN;
          end
        end
      end

      ST_CHECK: begin
        // Win is tested before the move count so a 9th-move win is not a draw.
        if (line_hits != 9'd0) begin
          winner_d    = turn_q ? 2'b10 : 2'b01;
          game_over_d = 1'b1;
`ifdef TTT_WINLINE_EN
          win_line_d  = line_hits;
`endif
          state_d     = ST_OVER;
        end else if (move_cnt_q == 4'd9) begin
          winner_d    = 2'b11;
          game_over_d = 1'b1;
`ifdef TTT_WINLINE_EN
          win_line_d  = '0;
`endif
          state_d     = ST_OVER;
        end else begin
          turn_d  = ~turn_q;
          state_d = ST_PLAY;
        end
      end

      default: begin
        if (key_evt_q && (key_idx_q == KEY_HASH || key_idx_q == KEY_STAR)) begin
          board_x_d   = '0;
          board_o_d   = '0;
          move_cnt_d  = '0;
          turn_d      = 1'b0;
          winner_d    = 2'b00;
          game_over_d = 1'b0;
`ifdef TTT_WINLINE_EN
          win_line_d  = '0;
`endif
          if (key_idx_q == KEY_STAR) begin
            in_main_d = 1'b1;
            state_d   = ST_MAIN;
          end else begin
            state_d   = ST_PLAY;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_MAIN;
      in_main_q   <= 1'b1;
      board_x_q   <= '0;
      board_o_q   <= '0;
      turn_q      <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 2'b00;
      move_cnt_q  <= '0;
      illegal_q   <= 1'b0;
`ifdef TTT_WINLINE_EN
      win_line_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      in_main_q   <= in_main_d;
      board_x_q   <= board_x_d;
      board_o_q   <= board_o_d;
      turn_q      <= turn_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      move_cnt_q  <= move_cnt_d;
      illegal_q   <= illegal_d;
`ifdef TTT_WINLINE_EN
      win_line_q  <= win_line_d;
`endif
    end
  end

  assign bus.in_main   = in_main_q;
  assign bus.board_x   = board_x_q;
  assign bus.board_o   = board_o_q;
  assign bus.turn_o    = turn_q;
  assign bus.game_over = game_over_q;
  assign bus.winner    = winner_q;
  assign bus.move_cnt  = move_cnt_q;
  assign bus.key_evt   = key_evt_q;
  assign bus.illegal   = illegal_q;
`ifdef TTT_WINLINE_EN
  assign bus.win_line  = win_line_q;
`endif

endmodule

// File: tb/tb_ttt_game_fsm.sv
// tb_ttt_game_fsm
// Directed bench for ttt_game_fsm with STABLE_CYC=4. Each press holds a key,
// releases it, and records key_evt/illegal pulses plus snapshots one and two
// cycles after the event. Checks on win_line are compiled in with TTT_WINLINE_EN.
module tb_ttt_game_fsm;
  logic clk;
  logic rst;
  int   errs;
  int   checks;

  int         evt_cnt;
  int         ill_cnt;
  logic [8:0] bx1;
  logic [1:0] win1;
  logic [1:0] win2;
  logic       turn1;
  logic       turn2;

  ttt_game_fsm_if bus ();

  ttt_game_fsm #(.STABLE_CYC(16'd4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic press(input logic [11:0] k, input int hold);
    int ev_at;
    evt_cnt = 0;
    ill_cnt = 0;
    ev_at   = -10;
    bus.key_data = k;
    for (int i = 0; i < 2 * hold + 6; i++) begin
      if (i == hold) bus.key_data = '0;
      @(negedge clk);
      if (bus.key_evt === 1'b1) begin
        evt_cnt++;
        ev_at = i;
      end
      if (bus.illegal === 1'b1) ill_cnt++;
      if (i == ev_at + 1) begin
        bx1   = bus.board_x;
        win1  = bus.winner;
        turn1 = bus.turn_o;
      end
      if (i == ev_at + 2) begin
        win2  = bus.winner;
        turn2 = bus.turn_o;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.key_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.in_main !== 1'b1) begin errs++; $display("FAIL reset_in_main got=%b exp=1", bus.in_main); end
    checks++; if (bus.board_x !== 9'h000 || bus.board_o !== 9'h000) begin errs++; $display("FAIL reset_board got=%h/%h exp=000/000", bus.board_x, bus.board_o); end
    checks++; if (bus.turn_o !== 1'b0 || bus.game_over !== 1'b0) begin errs++; $display("FAIL reset_turn_over got=%b/%b exp=0/0", bus.turn_o, bus.game_over); end
    checks++; if (bus.winner !== 2'b00 || bus.move_cnt !== 4'd0) begin errs++; $display("FAIL reset_winner_cnt got=%b/%0d exp=00/0", bus.winner, bus.move_cnt); end
    checks++; if (bus.key_evt !== 1'b0 || bus.illegal !== 1'b0) begin errs++; $display("FAIL reset_pulses got=%b/%b exp=0/0", bus.key_evt, bus.illegal); end
`ifdef TTT_WINLINE_EN
    checks++; if (bus.win_line !== 9'h000) begin errs++; $display("FAIL reset_win_line got=%h exp=000", bus.win_line); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start;
    press(12'h001, 10);
    checks++; if (evt_cnt !== 1) begin errs++; $display("FAIL start_evt_count got=%0d exp=1", evt_cnt); end
    checks++; if (bus.in_main !== 1'b0 || bus.turn_o !== 1'b0) begin errs++; $display("FAIL start_screen got=%b/%b exp=0/0", bus.in_main, bus.turn_o); end
    press(12'h001, 10);
    checks++; if (bx1 !== 9'h001 || turn1 !== 1'b0) begin errs++; $display("FAIL first_move_n1 got=%h/%b exp=001/0", bx1, turn1); end
    checks++; if (turn2 !== 1'b1) begin errs++; $display("FAIL first_move_turn_n2 got=%b exp=1", turn2); end
    checks++; if (bus.board_x !== 9'h001 || bus.turn_o !== 1'b1 || bus.move_cnt !== 4'd1) begin errs++; $display("FAIL first_move got=%h/%b/%0d exp=001/1/1", bus.board_x, bus.turn_o, bus.move_cnt); end
  endtask

  task automatic test_illegal;
    press(12'h001, 10);
    checks++; if (ill_cnt !== 1) begin errs++; $display("FAIL illegal_pulses got=%0d exp=1", ill_cnt); end
    checks++; if (bus.board_x !== 9'h001 || bus.board_o !== 9'h000 || bus.turn_o !== 1'b1 || bus.move_cnt !== 4'd1) begin
      errs++; $display("FAIL illegal_state got=%h/%h/%b/%0d exp=001/000/1/1", bus.board_x, bus.board_o, bus.turn_o, bus.move_cnt);
    end
  endtask

  task automatic test_win;
    press(12'h008, 10);
    press(12'h002, 10);
    press(12'h010, 10);
    press(12'h004, 10);
    checks++; if (bx1 !== 9'h007 || win1 !== 2'b00) begin errs++; $display("FAIL win_latency_n1 got=%h/%b exp=007/00", bx1, win1); end
    checks++; if (win2 !== 2'b01) begin errs++; $display("FAIL win_latency_n2 got=%b exp=01", win2); end
    checks++; if (bus.board_x !== 9'h007 || bus.board_o !== 9'h018) begin errs++; $display("FAIL win_board got=%h/%h exp=007/018", bus.board_x, bus.board_o); end
    checks++; if (bus.winner !== 2'b01 || bus.game_over !== 1'b1 || bus.move_cnt !== 4'd5) begin errs++; $display("FAIL win_result got=%b/%b/%0d exp=01/1/5", bus.winner, bus.game_over, bus.move_cnt); end
`ifdef TTT_WINLINE_EN
    checks++; if (bus.win_line !== 9'h007) begin errs++; $display("FAIL win_line got=%h exp=007", bus.win_line); end
`endif
  endtask

  task automatic test_over_keys;
    press(12'h100, 10);
    press(12'h400, 10);
    checks++; if (bus.board_x !== 9'h007 || bus.move_cnt !== 4'd5 || bus.game_over !== 1'b1 || ill_cnt !== 0) begin
      errs++; $display("FAIL over_frozen got=%h/%0d/%b/%0d exp=007/5/1/0", bus.board_x, bus.move_cnt, bus.game_over, ill_cnt);
    end
    press(12'h800, 10);
    checks++; if (bus.board_x !== 9'h000 || bus.board_o !== 9'h000 || bus.move_cnt !== 4'd0) begin errs++; $display("FAIL replay_board got=%h/%h/%0d exp=000/000/0", bus.board_x, bus.board_o, bus.move_cnt); end
    checks++; if (bus.winner !== 2'b00 || bus.game_over !== 1'b0 || bus.turn_o !== 1'b0 || bus.in_main !== 1'b0) begin
      errs++; $display("FAIL replay_flags got=%b/%b/%b/%b exp=00/0/0/0", bus.winner, bus.game_over, bus.turn_o, bus.in_main);
    end
`ifdef TTT_WINLINE_EN
    checks++; if (bus.win_line !== 9'h000) begin errs++; $display("FAIL replay_win_line got=%h exp=000", bus.win_line); end
`endif
  endtask

  task automatic test_draw;
    int cells [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    logic [11:0] kv;
    for (int m = 0; m < 9; m++) begin
      kv = 12'h001 << cells[m];
      press(kv, 10);
    end
    checks++; if (bus.board_x !== 9'h18D || bus.board_o !== 9'h072) begin errs++; $display("FAIL draw_board got=%h/%h exp=18d/072", bus.board_x, bus.board_o); end
    checks++; if (bus.move_cnt !== 4'd9 || bus.winner !== 2'b11 || bus.game_over !== 1'b1) begin errs++; $display("FAIL draw_result got=%0d/%b/%b exp=9/11/1", bus.move_cnt, bus.winner, bus.game_over); end
`ifdef TTT_WINLINE_EN
    checks++; if (bus.win_line !== 9'h000) begin errs++; $display("FAIL draw_win_line got=%h exp=000", bus.win_line); end
`endif
    press(12'h800, 10);
  endtask

  task automatic test_ninth_win;
    int cells [9] = '{1, 0, 3, 2, 6, 4, 7, 5, 8};
    logic [11:0] kv;
    for (int m = 0; m < 9; m++) begin
      kv = 12'h001 << cells[m];
      press(kv, 10);
    end
    checks++; if (bus.board_x !== 9'h1CA || bus.board_o !== 9'h035) begin errs++; $display("FAIL ninth_board got=%h/%h exp=1ca/035", bus.board_x, bus.board_o); end
    checks++; if (bus.move_cnt !== 4'd9 || bus.winner !== 2'b01) begin errs++; $display("FAIL ninth_result got=%0d/%b exp=9/01", bus.move_cnt, bus.winner); end
`ifdef TTT_WINLINE_EN
    checks++; if (bus.win_line !== 9'h1C0) begin errs++; $display("FAIL ninth_win_line got=%h exp=1c0", bus.win_line); end
`endif
    press(12'h200, 10);
    checks++; if (bus.in_main !== 1'b1 || bus.board_x !== 9'h000 || bus.game_over !== 1'b0 || bus.winner !== 2'b00) begin
      errs++; $display("FAIL over_to_main got=%b/%h/%b/%b exp=1/000/0/00", bus.in_main, bus.board_x, bus.game_over, bus.winner);
    end
  endtask

  task automatic test_qualifier;
    press(12'h003, 20);
    checks++; if (evt_cnt !== 0 || bus.in_main !== 1'b1) begin errs++; $display("FAIL multihot got=%0d/%b exp=0/1", evt_cnt, bus.in_main); end
    press(12'h010, 3);
    checks++; if (evt_cnt !== 0) begin errs++; $display("FAIL glitch_evt got=%0d exp=0", evt_cnt); end
    press(12'h002, 10);
    checks++; if (evt_cnt !== 1 || bus.in_main !== 1'b1) begin errs++; $display("FAIL main_ignore got=%0d/%b exp=1/1", evt_cnt, bus.in_main); end
    press(12'h001, 10);
    checks++; if (evt_cnt !== 1 || bus.in_main !== 1'b0) begin errs++; $display("FAIL restart got=%0d/%b exp=1/0", evt_cnt, bus.in_main); end
  endtask

  task automatic test_abort;
    press(12'h010, 10);
    checks++; if (bus.board_x !== 9'h010) begin errs++; $display("FAIL abort_pre got=%h exp=010", bus.board_x); end
    press(12'h200, 10);
    checks++; if (bus.in_main !== 1'b1 || bus.board_x !== 9'h000 || bus.board_o !== 9'h000 || bus.move_cnt !== 4'd0) begin
      errs++; $display("FAIL abort got=%b/%h/%h/%0d exp=1/000/000/0", bus.in_main, bus.board_x, bus.board_o, bus.move_cnt);
    end
  endtask

  task automatic test_reset_in_over;
    press(12'h001, 10);
    press(12'h001, 10);
    press(12'h008, 10);
    press(12'h002, 10);
    press(12'h010, 10);
    press(12'h004, 10);
    checks++; if (bus.game_over !== 1'b1) begin errs++; $display("FAIL pre_reset_over got=%b exp=1", bus.game_over); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.in_main !== 1'b1 || bus.board_x !== 9'h000 || bus.board_o !== 9'h000 || bus.game_over !== 1'b0) begin
      errs++; $display("FAIL async_reset_a got=%b/%h/%h/%b exp=1/000/000/0", bus.in_main, bus.board_x, bus.board_o, bus.game_over);
    end
    checks++; if (bus.winner !== 2'b00 || bus.move_cnt !== 4'd0 || bus.turn_o !== 1'b0) begin
      errs++; $display("FAIL async_reset_b got=%b/%0d/%b exp=00/0/0", bus.winner, bus.move_cnt, bus.turn_o);
    end
`ifdef TTT_WINLINE_EN
    checks++; if (bus.win_line !== 9'h000) begin errs++; $display("FAIL async_reset_win_line got=%h exp=000", bus.win_line); end
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    rst    = 1'b1;
    bus.key_data = '0;
    test_reset;
    test_start;
    test_illegal;
    test_win;
    test_over_keys;
    test_draw;
    test_ninth_win;
    test_qualifier;
    test_abort;
    test_reset_in_over;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
